cgra_bridge_loader: RTL and testbench

CGRA_BRIDGE_LOADER -- requirements
Module: cgra_bridge_loader

---
 rtl/cgra_bridge_loader.sv | 173 +++++++++++++++++
 tb/tb_cgra_bridge_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_bridge_loader.sv
// cgra_bridge_loader
// Streams a CGRA configuration image (instruction rows followed by kernel
// configuration words) from a valid/ready source onto the CGRA bridge write
// port, one word per cycle, addresses 0..IMG_LEN-1 in order.
// Optional feature: define CGRA_LOADER_CHECKSUM_EN to append a trailing
// 32-bit checksum word that is compared against the sum of all written data.
module cgra_bridge_loader #(
  parameter int N_ROWS         = 4,
  parameter int RC_INSTR_N_REG = 128,
  parameter int KER_CONF_N_REG = 16,
  parameter int KMEM_WIDTH     = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [9:0]  cgra_bridge_addr_o,
  output logic [31:0] cgra_bridge_wdata_o,
  output logic        cgra_bridge_we_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int          INSTR_WORDS = N_ROWS * RC_INSTR_N_REG;
  localparam int          IMG_LEN     = INSTR_WORDS + KER_CONF_N_REG;
  localparam logic [9:0]  LAST_IDX    = 10'(IMG_LEN - 1);
  localparam logic [9:0]  KER_BASE    = 10'(INSTR_WORDS);
  localparam logic [31:0] KMEM_MASK   = 32'((64'd1 << KMEM_WIDTH) - 64'd1);

`ifdef CGRA_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  state_t      state_reg, state_next;
  logic [9:0]  idx_reg, idx_next;
  logic        err_reg, err_next;
  logic        done_reg, done_next;
  logic        we_reg, we_next;
  logic [9:0]  addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        accept;
  logic [31:0] masked_data;
`ifdef CGRA_LOADER_CHECKSUM_EN
  logic [31:0] sum_reg, sum_next;
`endif

  // The source may hand over a word only while a load is running and no
  // abort is pending; the checksum word is taken in CHECK as well.
`ifdef CGRA_LOADER_CHECKSUM_EN
  assign in_ready_o = ((state_reg == LOAD) || (state_reg == CHECK)) && !abort_i;
`else
  assign in_ready_o = (state_reg == LOAD) && !abort_i;
`endif
  assign accept = in_valid_i && in_ready_o;

  // Kernel-configuration words only carry KMEM_WIDTH meaningful bits.
  assign masked_data = (idx_reg >= KER_BASE) ? (in_data_i & KMEM_MASK) : in_data_i;

  assign busy_o              = (state_reg != IDLE);
  assign done_o              = done_reg;
  assign err_o               = err_reg;
  assign cgra_bridge_we_o    = we_reg;
  assign cgra_bridge_addr_o  = addr_reg;
  assign cgra_bridge_wdata_o = wdata_reg;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, index, flags and the next bridge write (zero when idle).
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    we_next    = 1'b0;
    addr_next  = 10'd0;
    wdata_next = 32'd0;
`ifdef CGRA_LOADER_CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = LOAD;
          idx_next   = 10'd0;
          err_next   = 1'b0;
`ifdef CGRA_LOADER_CHECKSUM_EN
          sum_next   = 32'd0;
`endif
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (accept) begin
          we_next    = 1'b1;
          addr_next  = idx_reg;
          wdata_next = masked_data;
`ifdef CGRA_LOADER_CHECKSUM_EN
          sum_next   = sum_reg + masked_data;
`endif
          if (idx_reg == LAST_IDX) begin
`ifdef CGRA_LOADER_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end else begin
            idx_next = idx_reg + 10'd1;
          end
        end
      end
`ifdef CGRA_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort_i) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (accept) begin
          state_next = IDLE;
          if (in_data_i == sum_reg) begin
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: word index, sticky error, done pulse, bridge write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_reg   <= 10'd0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 10'd0;
      wdata_reg <= 32'd0;
`ifdef CGRA_LOADER_CHECKSUM_EN
      sum_reg   <= 32'd0;
`endif
    end else begin
      idx_reg   <= idx_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
`ifdef CGRA_LOADER_CHECKSUM_EN
      sum_reg   <= sum_next;
`endif
    end
  end

endmodule

// File: tb/tb_cgra_bridge_loader.sv
// Testbench for cgra_bridge_loader: an abstract phase/queue model of the
// loader checked every cycle, plus literal expectations per scenario.
module tb_cgra_bridge_loader;

  localparam int          IMG_LEN  = 528;
  localparam int          KER_BASE = 512;
  localparam logic [31:0] KMASK    = 32'h0000_7FFF;
`ifdef CGRA_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  br_addr;
  logic [31:0] br_wdata;
  logic        br_we;
  logic        busy;
  logic        done;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cgra_bridge_loader dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .abort_i             (abort),
    .in_data_i           (in_data),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .cgra_bridge_addr_o  (br_addr),
    .cgra_bridge_wdata_o (br_wdata),
    .cgra_bridge_we_o    (br_we),
    .busy_o              (busy),
    .done_o              (done),
    .err_o               (err)
  );

  // Abstract model: phase 0 idle, 1 receiving image, 2 awaiting checksum.
  int          m_phase = 0;
  int          m_idx   = 0;
  bit          m_err   = 1'b0;
  logic [31:0] m_sum   = 32'd0;
  bit          e_we    = 1'b0;
  bit          e_done  = 1'b0;
  logic [9:0]  e_addr  = 10'd0;
  logic [31:0] e_wdata = 32'd0;

  always @(posedge clk or posedge rst) begin : model_blk
    logic [31:0] w;
    if (rst) begin
      m_phase = 0; m_idx = 0; m_err = 1'b0; m_sum = 32'd0;
      e_we = 1'b0; e_done = 1'b0; e_addr = 10'd0; e_wdata = 32'd0;
    end else begin
      e_we = 1'b0; e_done = 1'b0; e_addr = 10'd0; e_wdata = 32'd0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_idx = 0; m_err = 1'b0; m_sum = 32'd0;
        end
      end else if (abort) begin
        m_phase = 0; m_err = 1'b1;
      end else if (in_valid) begin
        if (m_phase == 1) begin
          w = (m_idx >= KER_BASE) ? (in_data & KMASK) : in_data;
          e_we = 1'b1; e_addr = 10'(m_idx); e_wdata = w;
          m_sum = m_sum + w;
          m_idx = m_idx + 1;
          if (m_idx == IMG_LEN) begin
            if (CHK) m_phase = 2;
            else begin m_phase = 0; e_done = 1'b1; end
          end
        end else begin
          m_phase = 0;
          if (in_data == m_sum) e_done = 1'b1;
          else m_err = 1'b1;
        end
      end
    end
  end

  // Scoreboard of observed writes for the per-scenario literal checks.
  int          wr_count = 0;
  int          last_wr_addr = -1;
  int          done_cnt = 0;
  int          done_addr = -1;
  bit          done_we = 1'b0;
  logic [31:0] w512 = 32'd0;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp_blk
    bit exp_ready;
    bit exp_busy;
    exp_ready = ((m_phase == 1) || (CHK && m_phase == 2)) && !abort;
    exp_busy  = (m_phase != 0);
    compared++;
    if ({in_ready, busy, br_we, br_addr, br_wdata, done, err} !==
        {exp_ready, exp_busy, e_we, e_addr, e_wdata, e_done, m_err}) begin
      mismatched++;
      if (mismatched < 25)
        $display("FAIL cycle_check t=%0t: got rdy=%b busy=%b we=%b addr=%0d wdata=%08h done=%b err=%b, expected rdy=%b busy=%b we=%b addr=%0d wdata=%08h done=%b err=%b",
                 $time, in_ready, busy, br_we, br_addr, br_wdata, done, err,
                 exp_ready, exp_busy, e_we, e_addr, e_wdata, e_done, m_err);
    end
    if (br_we === 1'b1) begin
      compared++;
      if (int'(br_addr) != wr_count) begin
        mismatched++;
        if (mismatched < 25)
          $display("FAIL addr_contiguous t=%0t: got addr %0d expected %0d", $time, br_addr, wr_count);
      end
      wr_count++;
      last_wr_addr = int'(br_addr);
      if (br_addr == 10'd512) w512 = br_wdata;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_addr = int'(br_addr);
      done_we = br_we;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    wr_count = 0; last_wr_addr = -1; done_cnt = 0; done_addr = -1;
    done_we = 1'b0; w512 = 32'd0;
  endtask

  function automatic logic [31:0] pat(input int p, input int i);
    if (p == 0) return 32'(i);
    if (i == 512) return 32'hFFFF_FFFF;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Drives one image load. chk: 0 no trailer, 1 correct sum, 2 sum+1.
  task automatic run_load(input int p, input bit toggle, input int abort_at,
                          input int chk, input bit dup_start, input bit abort_with_start);
    int i;
    int cyc;
    bit aborted;
    logic [31:0] sum;
    logic [31:0] d;
    clear_sb();
    @(posedge clk); #1;
    start = 1'b1; abort = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    i = 0; cyc = 0; sum = 32'd0; aborted = 1'b0;
    while (i < IMG_LEN) begin
      d = pat(p, i);
      in_data  = d;
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      start    = dup_start && (i == 200);
      if (abort_at == i && in_valid) abort = 1'b1;
      @(posedge clk); #1;
      if (abort) begin
        abort = 1'b0; in_valid = 1'b0; start = 1'b0; aborted = 1'b1;
        break;
      end
      if (in_valid) begin
        sum = sum + ((i >= KER_BASE) ? (d & KMASK) : d);
        i++;
      end
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (!aborted && chk != 0) begin
      in_data  = sum + ((chk == 2) ? 32'd1 : 32'd0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_we", {31'd0, br_we}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_ready", {31'd0, in_ready}, 32'd0);
    $display("test reset: we=%b busy=%b done=%b err=%b", br_we, busy, done, err);
    rst = 1'b0;

    // Full image, value = index, valid held high
    run_load(0, 1'b0, -1, 1, 1'b0, 1'b0);
    check("full_writes", 32'(wr_count), 32'd528);
    check("full_last_addr", 32'(last_wr_addr), 32'd527);
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    check("full_err", {31'd0, err}, 32'd0);
    if (!CHK) begin
      check("full_done_addr", 32'(done_addr), 32'd527);
      check("full_done_with_we", {31'd0, done_we}, 32'd1);
    end else begin
      check("full_done_after_sum", {31'd0, done_we}, 32'd0);
    end
    $display("test full_load: writes=%0d last=%0d done=%0d err=%b", wr_count, last_wr_addr, done_cnt, err);

    // Kernel word masking, redundant start mid-load, wrong checksum
    run_load(1, 1'b0, -1, 2, 1'b1, 1'b0);
    check("mask_w512", w512, 32'h0000_7FFF);
    check("mask_writes", 32'(wr_count), 32'd528);
    check("mask_err", {31'd0, err}, CHK ? 32'd1 : 32'd0);
    check("mask_done_cnt", 32'(done_cnt), CHK ? 32'd0 : 32'd1);
    $display("test mask_badsum: w512=%08h writes=%0d done=%0d err=%b", w512, wr_count, done_cnt, err);

    // Valid toggling every cycle
    run_load(0, 1'b1, -1, 1, 1'b0, 1'b0);
    check("toggle_writes", 32'(wr_count), 32'd528);
    check("toggle_last_addr", 32'(last_wr_addr), 32'd527);
    check("toggle_err", {31'd0, err}, 32'd0);
    check("toggle_done_cnt", 32'(done_cnt), 32'd1);
    $display("test toggle: writes=%0d last=%0d done=%0d err=%b", wr_count, last_wr_addr, done_cnt, err);

    // Abort at index 100
    run_load(0, 1'b0, 100, 1, 1'b0, 1'b0);
    check("abort_writes", 32'(wr_count), 32'd100);
    check("abort_last_addr", 32'(last_wr_addr), 32'd99);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd1);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    $display("test abort: writes=%0d last=%0d done=%0d err=%b", wr_count, last_wr_addr, done_cnt, err);

    // Restart with start and abort together in idle: start wins
    run_load(0, 1'b0, -1, 1, 1'b0, 1'b1);
    check("restart_writes", 32'(wr_count), 32'd528);
    check("restart_err", {31'd0, err}, 32'd0);
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    $display("test restart: writes=%0d done=%0d err=%b", wr_count, done_cnt, err);

    // Reset mid-load at index 300
    clear_sb();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_data = 32'(i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", {31'd0, br_we}, 32'd0);
    check("rst_mid_addr", {22'd0, br_addr}, 32'd0);
    check("rst_mid_wdata", br_wdata, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    clear_sb();
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_no_writes", 32'(wr_count), 32'd0);
    check("rst_idle", {31'd0, busy}, 32'd0);
    $display("test reset_midload: writes_after_release=%0d busy=%b", wr_count, busy);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
